// File: rtl/ram_burst_ctrl_pkg.sv
// ram_ctrl_pkg: shared types and helpers for the command-decoded burst RAM.
//   opcode_e  : 2-bit command opcode carried in din[DATA_WIDTH+1:DATA_WIDTH]
//   state_e   : read-return FSM states
//   OPCODE_W  : opcode field width
//   idx_width : array index width for a given memory depth
package ram_ctrl_pkg;

  localparam int unsigned OPCODE_W = 2;

  typedef enum logic [OPCODE_W-1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } opcode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_e;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_burst_ctrl_store.sv
// ram_store: single-port word array, synchronous write, registered read.
// Optional macro RAM_BURST_PARITY_EN adds one even-parity bit per word.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset (read register only)
//   we_i, waddr_i, wdata_i   write strobe, index, data
//   re_i, rzero_i, raddr_i   read strobe, force-zero result, index
//   rdata_o              registered read data
//   rpar_o               registered stored parity (RAM_BURST_PARITY_EN only)
module ram_store
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256,
  localparam int unsigned IW   = idx_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [IW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic             rzero_i,
  input  logic [IW-1:0]    raddr_i,
`ifdef RAM_BURST_PARITY_EN
  output logic             rpar_o,
`endif
  output logic [WIDTH-1:0] rdata_o
);

`ifdef RAM_BURST_PARITY_EN
  localparam int unsigned SW = WIDTH + 1;
`else
  localparam int unsigned SW = WIDTH;
`endif

  logic [SW-1:0] mem [0:DEPTH-1];
  logic [SW-1:0] rword_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
`ifdef RAM_BURST_PARITY_EN
      mem[waddr_i] <= {^wdata_i, wdata_i};
`else
      mem[waddr_i] <= wdata_i;
`endif
    end
  end

  // rzero_i covers out-of-range reads: the index is never dereferenced then.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rword_q <= '0;
    end else if (re_i) begin
      rword_q <= rzero_i ? '0 : mem[raddr_i];
    end
  end

  assign rdata_o = rword_q[WIDTH-1:0];
`ifdef RAM_BURST_PARITY_EN
  assign rpar_o  = rword_q[WIDTH];
`endif

endmodule

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: command-decoded single-port RAM slave behind an SPI slave's
// parallel rx/tx interface, with optional address auto-increment, a
// backpressured read-return handshake and sticky out-of-range error.
// Optional macro RAM_BURST_PARITY_EN: per-word even parity, par_err output.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   din           {opcode[1:0], payload[DATA_WIDTH-1:0]} command word
//   rx_valid      din valid;  rx_ready: command can be accepted this cycle
//   dout          read data;  tx_valid: dout valid until tx_ready
//   tx_ready      consumer accepts dout
//   addr_err      sticky: access attempted at address >= MEM_DEPTH
//   par_err       stored parity mismatch on returned word (RAM_BURST_PARITY_EN)
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned AUTO_INC   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH+OPCODE_W-1:0] din,
  input  logic                           rx_valid,
  output logic                           rx_ready,
  output logic [DATA_WIDTH-1:0]          dout,
  output logic                           tx_valid,
  input  logic                           tx_ready,
`ifdef RAM_BURST_PARITY_EN
  output logic                           par_err,
`endif
  output logic                           addr_err
);

  localparam int unsigned IW       = idx_width(MEM_DEPTH);
  localparam logic [31:0] DEPTH_32 = 32'(MEM_DEPTH);
  localparam logic [31:0] LAST_32  = 32'(MEM_DEPTH - 1);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < DEPTH_32;
  endfunction

  // Wraps at MEM_DEPTH-1 (not 2**ADDR_WIDTH); out-of-range addresses also restart at 0.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    if (AUTO_INC == 0) return a;
    if (32'(a) >= LAST_32) return '0;
    return a + ADDR_WIDTH'(1);
  endfunction

  opcode_e                 op;
  logic [DATA_WIDTH-1:0]   payload;
  logic                    accept;
  logic                    rd_cmd;
  logic                    wr_ok;
  logic                    rd_ok;

  logic [ADDR_WIDTH-1:0]   addr_wr_q, addr_wr_d;
  logic [ADDR_WIDTH-1:0]   addr_rd_q, addr_rd_d;
  logic                    err_q, err_d;
  state_e                  state_q, state_d;

  assign op      = opcode_e'(din[DATA_WIDTH+OPCODE_W-1:DATA_WIDTH]);
  assign payload = din[DATA_WIDTH-1:0];

  assign tx_valid = (state_q == VALID);
  assign rx_ready = !(tx_valid && !tx_ready);
  assign accept   = rx_valid && rx_ready;
  assign rd_cmd   = accept && (op == RD_DATA);
  assign wr_ok    = in_range(addr_wr_q);
  assign rd_ok    = in_range(addr_rd_q);

  always_comb begin
    addr_wr_d = addr_wr_q;
    addr_rd_d = addr_rd_q;
    err_d     = err_q;
    if (accept) begin
      case (op)
        WR_ADDR: addr_wr_d = payload[ADDR_WIDTH-1:0];
        WR_DATA: begin
          addr_wr_d = next_addr(addr_wr_q);
          if (!wr_ok) err_d = 1'b1;
        end
        RD_ADDR: addr_rd_d = payload[ADDR_WIDTH-1:0];
        RD_DATA: begin
          addr_rd_d = next_addr(addr_rd_q);
          if (!rd_ok) err_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A read accepted while VALID is only possible with tx_ready high, so it
  // chains the next word; otherwise VALID holds until tx_ready.
  always_comb begin
    state_d = IDLE;
    if (rd_cmd) begin
      state_d = VALID;
    end else if ((state_q == VALID) && !tx_ready) begin
      state_d = VALID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_wr_q <= '0;
      addr_rd_q <= '0;
      err_q     <= 1'b0;
      state_q   <= IDLE;
    end else begin
      addr_wr_q <= addr_wr_d;
      addr_rd_q <= addr_rd_d;
      err_q     <= err_d;
      state_q   <= state_d;
    end
  end

  assign addr_err = err_q;

`ifdef RAM_BURST_PARITY_EN
  logic rpar;
`endif

  ram_store #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (MEM_DEPTH)
  ) u_store (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (accept && (op == WR_DATA) && wr_ok && !rst),
    .waddr_i (addr_wr_q[IW-1:0]),
    .wdata_i (payload),
    .re_i    (rd_cmd),
    .rzero_i (!rd_ok),
    .raddr_i (addr_rd_q[IW-1:0]),
`ifdef RAM_BURST_PARITY_EN
    .rpar_o  (rpar),
`endif
    .rdata_o (dout)
  );

`ifdef RAM_BURST_PARITY_EN
  assign par_err = tx_valid && (rpar != ^dout);
`endif

endmodule

// File: tb/tb_ram_burst_ctrl.sv
module tb_ram_burst_ctrl;
  import ram_ctrl_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW+1:0] din = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [DW-1:0] dout;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          addr_err;
`ifdef RAM_BURST_PARITY_EN
  logic          par_err;
`endif

  ram_burst_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_DEPTH  (DEPTH),
    .AUTO_INC   (1)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .dout     (dout),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
`ifdef RAM_BURST_PARITY_EN
    .par_err  (par_err),
`endif
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          perr;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] m_mem  [0:255];
  logic          m_pbad [0:255];
  logic [AW-1:0] m_wr = '0;
  logic [AW-1:0] m_rd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] m_next(input logic [AW-1:0] a);
    return (a >= AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  task automatic m_apply(input opcode_e op, input logic [DW-1:0] pl);
    exp_t e;
    case (op)
      WR_ADDR: m_wr = pl[AW-1:0];
      WR_DATA: begin
        if (m_wr < AW'(DEPTH)) begin
          m_mem[m_wr]  = pl;
          m_pbad[m_wr] = 1'b0;
        end
        m_wr = m_next(m_wr);
      end
      RD_ADDR: m_rd = pl[AW-1:0];
      default: begin
        e.data = (m_rd < AW'(DEPTH)) ? m_mem[m_rd] : '0;
        e.perr = (m_rd < AW'(DEPTH)) ? m_pbad[m_rd] : 1'b0;
        sb_q.push_back(e);
        m_rd = m_next(m_rd);
      end
    endcase
  endtask

  // Presents one command, waits (bounded) for rx_ready, then holds it across one edge.
  task automatic cmd(input opcode_e op, input logic [DW-1:0] pl);
    int unsigned n = 0;
    din      = {op, pl};
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!rx_ready) begin
      chk("cmd_accept_timeout", rx_ready, 1);
      rx_valid = 1'b0;
      return;
    end
    m_apply(op, pl);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((sb_q.size() != 0 || tx_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb_q.size(), 0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && tx_valid && tx_ready) begin
      if (sb_q.size() == 0) begin
        chk("tx_unexpected", tx_valid, 0);
      end else begin
        e = sb_q.pop_front();
        chk("rd_data", dout, e.data);
`ifdef RAM_BURST_PARITY_EN
        chk("par_err_word", par_err, e.perr);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_rx_ready", rx_ready, 1);
    @(posedge clk); #1;

    // Basic write/read with latency 1
    cmd(WR_ADDR, 8'h10);
    cmd(WR_DATA, 8'hA5);
    cmd(RD_ADDR, 8'h10);
    cmd(RD_DATA, 8'h00);
    @(negedge clk);
    chk("basic_tx_valid", tx_valid, 1);
    chk("basic_dout", dout, 8'hA5);
    @(negedge clk);
    chk("basic_tx_drop", tx_valid, 0);
    chk("basic_dout_hold", dout, 8'hA5);
    @(posedge clk); #1;

    // Burst across the wrap point at MEM_DEPTH-1
    cmd(WR_ADDR, 8'd198);
    cmd(WR_DATA, 8'h11);
    cmd(WR_DATA, 8'h22);
    cmd(WR_DATA, 8'h33);
    cmd(RD_ADDR, 8'd198);
    cmd(RD_DATA, 8'h00);
    cmd(RD_DATA, 8'h00);
    cmd(RD_DATA, 8'h00);
    cmd(RD_ADDR, 8'd0);
    cmd(RD_DATA, 8'h00);
    drain();

    // Backpressure: stalled WR_DATA to address 6 must not land
    cmd(WR_ADDR, 8'd5);
    cmd(WR_DATA, 8'h3C);
    cmd(WR_DATA, 8'h66);
    cmd(WR_ADDR, 8'd6);
    cmd(RD_ADDR, 8'd5);
    tx_ready = 1'b0;
    cmd(RD_DATA, 8'h00);
    din      = {WR_DATA, 8'hEE};
    rx_valid = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_tx_valid", tx_valid, 1);
      chk("bp_dout", dout, 8'h3C);
      chk("bp_rx_ready", rx_ready, 0);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_rx_ready", rx_ready, 1);
    @(negedge clk);
    chk("bp_release_tx_drop", tx_valid, 0);
    chk("bp_release_rx_ready2", rx_ready, 1);
    @(posedge clk); #1;
    cmd(RD_ADDR, 8'd6);
    cmd(RD_DATA, 8'h00);
    drain();

    // Non-power-of-two depth: wrap, out-of-range write/read, sticky error
    cmd(WR_ADDR, 8'd199);
    cmd(WR_DATA, 8'h5A);
    cmd(WR_DATA, 8'h5A);
    @(negedge clk);
    chk("oor_err_clear", addr_err, 0);
    @(posedge clk); #1;
    cmd(WR_ADDR, 8'd250);
    cmd(WR_DATA, 8'h77);
    @(negedge clk);
    chk("oor_wr_err", addr_err, 1);
    @(posedge clk); #1;
    cmd(WR_DATA, 8'h99);
    cmd(RD_ADDR, 8'd199);
    cmd(RD_DATA, 8'h00);
    cmd(RD_DATA, 8'h00);
    cmd(RD_ADDR, 8'd250);
    cmd(RD_DATA, 8'h00);
    cmd(RD_DATA, 8'h00);
    drain();
    chk("oor_err_sticky", addr_err, 1);

    // Reset while a read return is pending
    tx_ready = 1'b0;
    cmd(RD_ADDR, 8'd0);
    cmd(RD_DATA, 8'h00);
    @(negedge clk);
    chk("rstv_pending", tx_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tx_ready = 1'b1;
    sb_q.delete();
    m_wr = '0;
    m_rd = '0;
    @(negedge clk);
    chk("rstv_tx_valid", tx_valid, 0);
    chk("rstv_dout", dout, 0);
    chk("rstv_addr_err", addr_err, 0);
    chk("rstv_rx_ready", rx_ready, 1);
    @(posedge clk); #1;
    cmd(WR_DATA, 8'h42);
    cmd(RD_DATA, 8'h00);
    drain();

    // Write then read of the same address on consecutive cycles
    cmd(WR_ADDR, 8'd20);
    cmd(RD_ADDR, 8'd20);
    cmd(WR_DATA, 8'hC3);
    cmd(RD_DATA, 8'h00);
    drain();

`ifdef RAM_BURST_PARITY_EN
    cmd(WR_ADDR, 8'd3);
    cmd(WR_DATA, 8'h07);
    cmd(WR_DATA, 8'h0F);
    u_dut.u_store.mem[3][DW] = ~u_dut.u_store.mem[3][DW];
    m_pbad[3] = 1'b1;
    cmd(RD_ADDR, 8'd3);
    cmd(RD_DATA, 8'h00);
    @(negedge clk);
    chk("par_pulse", par_err, 1);
    @(negedge clk);
    chk("par_idle", par_err, 0);
    @(posedge clk); #1;
    cmd(RD_ADDR, 8'd3);
    cmd(RD_DATA, 8'h00);
    cmd(RD_DATA, 8'h00);
    drain();
    chk("par_after", par_err, 0);
`endif

    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
